// File: rtl/pwm_capture.sv
// pwm_capture: samples an asynchronous PWM input and measures its period
// (rising->rising) and high time (rising->falling) in clk cycles. A fresh
// pair is published with a one-cycle valid_o pulse at each completed period.
module pwm_capture #(
    parameter int CNT_W  = 9,
    parameter int SYNC_N = 2
) (
    input  logic             clk,
    input  logic             res_ni,
    input  logic             en_i,
    input  logic             pwm_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             lock_o
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_N-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  high_q, high_d;          // high time of the period in progress
    logic [CNT_W-1:0]  period_out_q, period_out_d;
    logic [CNT_W-1:0]  high_out_q, high_out_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic              lock_q, lock_d;

    logic             s, rise, fall;
    logic [CNT_W-1:0] cnt_inc;

    // Edge detection on the synchronized input and next-state / result logic
    always_comb begin
        sync_d       = {sync_q[SYNC_N-2:0], pwm_i};
        s            = sync_q[SYNC_N-1];
        prev_d       = s;
        rise         = s & ~prev_q;
        fall         = ~s & prev_q;
        // Saturating increment: a fall at max count must not wrap; the LOW
        // phase then times out on its first cycle unless a rise arrives.
        cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        state_d      = state_q;
        cnt_d        = cnt_q;
        high_d       = high_q;
        period_out_d = period_out_q;
        high_out_d   = high_out_q;
        valid_d      = 1'b0;
        timeout_d    = 1'b0;
        lock_d       = lock_q;

        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // First rise only opens a measurement; the partial period is dropped.
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        high_d  = cnt_q;
                        cnt_d   = cnt_inc;
                        state_d = LOW;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        lock_d    = 1'b0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOW: begin
                    // A rise at max count still wins over the timeout.
                    if (rise) begin
                        period_out_d = cnt_q;
                        high_out_d   = high_q;
                        valid_d      = 1'b1;
                        lock_d       = 1'b1;
                        cnt_d        = CNT_ONE;
                        state_d      = HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        lock_d    = 1'b0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res_ni) begin
            sync_q       <= '0;
            prev_q       <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            high_q       <= '0;
            period_out_q <= '0;
            high_out_q   <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            lock_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            high_q       <= high_d;
            period_out_q <= period_out_d;
            high_out_q   <= high_out_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
            lock_q       <= lock_d;
        end
    end

    assign period_o  = period_out_q;
    assign high_o    = high_out_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;
    assign lock_o    = lock_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: clean waveforms, minimum pulse widths,
// timeout at the counter limit, disable and reset in mid-measurement.
module tb_pwm_capture;

    localparam int CNT_W  = 9;
    localparam int SYNC_N = 2;
    localparam int LAT    = SYNC_N;   // posedges from sampling edge to the valid edge

    logic             clk = 1'b0;
    logic             res_ni, en_i, pwm_i;
    logic [CNT_W-1:0] period_o, high_o;
    logic             valid_o, timeout_o, lock_o;

    int vectors = 0;
    int errs    = 0;

    // monitor counters
    int cyc = 0, vcnt = 0, vcyc = -1, tcnt = 0, tcyc = -1, both = 0;

    pwm_capture #(.CNT_W(CNT_W), .SYNC_N(SYNC_N)) dut (
        .clk       (clk),
        .res_ni    (res_ni),
        .en_i      (en_i),
        .pwm_i     (pwm_i),
        .period_o  (period_o),
        .high_o    (high_o),
        .valid_o   (valid_o),
        .timeout_o (timeout_o),
        .lock_o    (lock_o)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping, sampled 1 ns after each active edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (valid_o) begin vcnt = vcnt + 1; vcyc = cyc; end
        if (timeout_o) begin tcnt = tcnt + 1; tcyc = cyc; end
        if (valid_o && timeout_o) both = both + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        vectors = vectors + 1;
        assert (got === exp) else begin
            errs = errs + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive pwm_i at a negedge and hold it for n active edges
    task automatic hold(input logic v, input int n);
        pwm_i = v;
        repeat (n) @(negedge clk);
    endtask

    int r, v0, t0;

    initial begin
        res_ni = 1'b0; en_i = 1'b1; pwm_i = 1'b0;
        @(negedge clk);
        hold(0, 3);
        res_ni = 1'b1;
        check("rst_period", period_o, 0);
        check("rst_high", high_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_lock", lock_o, 0);
        hold(0, 2);

        // Minimum widths: high 1 / low 1, six rises -> five valids
        v0 = vcnt;
        for (int i = 0; i < 6; i++) begin
            r = cyc + 1;
            hold(1, 1);
            hold(0, 1);
        end
        hold(0, 3);
        check("min_vcnt", vcnt - v0, 5);
        check("min_period", period_o, 2);
        check("min_high", high_o, 1);
        check("min_latency", vcyc, r + LAT);
        check("min_lock", lock_o, 1);

        // Period 10 / high 3 (generator loopback waveform), four rises
        v0 = vcnt;
        for (int i = 0; i < 4; i++) begin
            r = cyc + 1;
            hold(1, 3);
            hold(0, 7);
        end
        check("p10_vcnt", vcnt - v0, 4);
        check("p10_period", period_o, 10);
        check("p10_high", high_o, 3);
        check("p10_latency", vcyc, r + LAT);

        // Stuck high -> timeout at cnt=511, results held
        t0 = tcnt;
        r = cyc + 1;
        hold(1, 600);
        check("stk_tcnt", tcnt - t0, 1);
        check("stk_tcyc", tcyc, r + LAT + 511);
        check("stk_lock", lock_o, 0);
        check("stk_period", period_o, 10);
        check("stk_high", high_o, 3);
        v0 = vcnt;
        hold(0, 5);
        hold(1, 4);
        hold(0, 8);
        check("stk_novalid", vcnt - v0, 0);
        hold(1, 4);
        hold(0, 3);
        check("stk_relock_vcnt", vcnt - v0, 1);
        check("stk_relock_period", period_o, 12);
        check("stk_relock_high", high_o, 4);
        check("stk_relock_lock", lock_o, 1);

        // Period exactly 511 measures; the open period from that rise times out
        t0 = tcnt; v0 = vcnt;
        hold(0, 504);
        r = cyc + 1;
        hold(1, 2);
        hold(0, 4);
        check("p511_vcnt", vcnt - v0, 1);
        check("p511_period", period_o, 511);
        check("p511_high", high_o, 4);
        check("p511_tcnt", tcnt - t0, 0);
        hold(0, 506);
        hold(1, 3);
        check("p512_tcnt", tcnt - t0, 1);
        check("p512_tcyc", tcyc, r + LAT + 511);
        check("p512_vcnt", vcnt - v0, 1);
        check("p512_period", period_o, 511);
        check("p512_lock", lock_o, 0);

        // Disable for 3 clk in mid-HIGH
        hold(0, 7);
        hold(1, 3);
        hold(0, 7);
        check("en_pre_period", period_o, 10);
        hold(1, 3);
        v0 = vcnt; t0 = tcnt;
        en_i = 1'b0;
        hold(1, 3);
        check("en_off_lock", lock_o, 0);
        check("en_off_period", period_o, 10);
        check("en_off_high", high_o, 3);
        en_i = 1'b1;
        hold(0, 6);
        hold(1, 3);
        hold(0, 7);
        check("en_first_rise", vcnt - v0, 0);
        r = cyc + 1;
        hold(1, 3);
        hold(0, 7);
        check("en_relock_vcnt", vcnt - v0, 1);
        check("en_relock_lat", vcyc, r + LAT);
        check("en_relock_period", period_o, 10);
        check("en_no_timeout", tcnt - t0, 0);

        // Reset for 1 clk in mid-LOW
        hold(1, 3);
        hold(0, 2);
        res_ni = 1'b0;
        hold(0, 1);
        res_ni = 1'b1;
        check("mrst_period", period_o, 0);
        check("mrst_high", high_o, 0);
        check("mrst_lock", lock_o, 0);
        check("mrst_valid", valid_o, 0);
        v0 = vcnt;
        hold(1, 2);
        hold(0, 4);
        check("mrst_first_rise", vcnt - v0, 0);
        hold(1, 2);
        hold(0, 4);
        check("mrst_vcnt", vcnt - v0, 1);
        check("mrst_period6", period_o, 6);
        check("mrst_high2", high_o, 2);

        check("never_both", both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
